// File: rtl/syn_current.sv
// rtl/syn_current.sv - synaptic current accumulator with per-step exponential decay
module syn_current #(
  parameter int TAU_SHIFT = 4,
  parameter int W         = 37
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                step,
  input  logic                syn_valid,
  input  logic signed [W-1:0] syn_weight,
  output logic                syn_ready,
  output logic signed [W-1:0] cur_out,
  output logic                cur_valid,
  input  logic                cur_ready,
  output logic [7:0]          evt_cnt,
  output logic                overrun
);

  typedef enum logic [1:0] {ACCUM, DECAY, PRESENT} state_t;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  state_t              state, state_nxt;
  logic signed [W-1:0] acc;
  logic [7:0]          cnt;
  logic                accept;
  logic signed [W-1:0] w_in;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] decayed;
  logic [7:0]          cnt_inc;

  // One guard bit catches overflow; clamp instead of wrapping.
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? SAT_MIN : SAT_MAX;
    return s[W-1:0];
  endfunction

  assign accept  = syn_valid && (state == ACCUM);
  assign w_in    = accept ? syn_weight : '0;
  assign sum     = sat_add(acc, w_in);
  assign decayed = cur_out - (cur_out >>> TAU_SHIFT);
  assign cnt_inc = (accept && (cnt != 8'hFF)) ? cnt + 8'd1 : cnt;

  always_comb begin
    state_nxt = state;
    syn_ready = 1'b0;
    case (state)
      ACCUM: begin
        syn_ready = 1'b1;
        if (step) state_nxt = DECAY;
      end
      DECAY:   state_nxt = PRESENT;
      PRESENT: if (cur_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      cur_out   <= '0;
      cur_valid <= 1'b0;
      evt_cnt   <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      // A step arriving while the previous result is still in flight is lost.
      if (step && (state != ACCUM)) overrun <= 1'b1;
      case (state)
        ACCUM: begin
          if (clr) begin
            acc <= '0;
            cnt <= '0;
            if (step) begin
              cur_out <= '0;
              evt_cnt <= '0;
            end
          end else if (step) begin
            cur_out <= sum;
            acc     <= sum;
            evt_cnt <= cnt_inc;
            cnt     <= '0;
          end else begin
            acc <= sum;
            cnt <= cnt_inc;
          end
        end
        DECAY: begin
          acc       <= clr ? '0 : decayed;
          cur_valid <= 1'b1;
        end
        PRESENT: begin
          if (clr) acc <= '0;
          if (cur_ready) cur_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
